// File: rtl/note_lane_sequencer_if.sv
// Square-drawer bus between the note lane sequencer and the drawer.
// master: drives go/x/y/colour and receives done; slave is the drawer side.
interface note_lane_sequencer_if;
    logic       sq_go;
    logic [7:0] sq_x;
    logic [6:0] sq_y;
    logic [2:0] sq_colour;
    logic       sq_done;

    modport master (
        output sq_go,
        output sq_x,
        output sq_y,
        output sq_colour,
        input  sq_done
    );

    modport slave (
        input  sq_go,
        input  sq_x,
        input  sq_y,
        input  sq_colour,
        output sq_done
    );
endinterface

// File: rtl/note_lane_sequencer.sv
// Scrolls two 10-slot note lanes and redraws each slot as a square.
// Ports: clk/reset, tick/load requests, 10-bit red/yellow patterns, the
// square-drawer bus (sq), busy, frame_done, lane_head and overrun.
module note_lane_sequencer #(
    parameter logic [7:0] LANE_X0 = 8'd10,
    parameter logic [6:0] LANE_Y  = 7'd56,
    parameter logic [7:0] PITCH   = 8'd12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [9:0] red_seq_in,
    input  logic [9:0] yellow_seq_in,
    note_lane_sequencer_if.master sq,
    output logic       busy,
    output logic       frame_done,
    output logic [1:0] lane_head,
    output logic       overrun
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t     state;
    logic [9:0] red_q;
    logic [9:0] yellow_q;
    logic [3:0] slot;
    logic       pending;

    logic [9:0] red_sh;
    logic [9:0] yel_sh;
    logic [3:0] slot_nxt;

    // Red has priority when both lanes hold a note in the same slot.
    function automatic logic [2:0] colour_of(input logic r, input logic y);
        if (r)
            return 3'b100;
        else if (y)
            return 3'b110;
        else
            return 3'b000;
    endfunction

    always_comb begin
        red_sh   = {1'b0, red_q[9:1]};
        yel_sh   = {1'b0, yellow_q[9:1]};
        slot_nxt = slot + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            red_q        <= '0;
            yellow_q     <= '0;
            slot         <= '0;
            pending      <= 1'b0;
            sq.sq_go     <= 1'b0;
            sq.sq_x      <= '0;
            sq.sq_y      <= '0;
            sq.sq_colour <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            lane_head    <= '0;
            overrun      <= 1'b0;
        end else begin
            sq.sq_go   <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;

            unique case (state)
                IDLE: begin
                    // A simultaneous tick is dropped silently: load wins.
                    if (load) begin
                        red_q        <= red_seq_in;
                        yellow_q     <= yellow_seq_in;
                        slot         <= '0;
                        sq.sq_x      <= LANE_X0;
                        sq.sq_y      <= LANE_Y;
                        sq.sq_colour <= colour_of(red_seq_in[0],
                                                  yellow_seq_in[0]);
                        sq.sq_go     <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ISSUE;
                    end else if (tick || pending) begin
                        lane_head    <= {yellow_q[0], red_q[0]};
                        red_q        <= red_sh;
                        yellow_q     <= yel_sh;
                        slot         <= '0;
                        pending      <= 1'b0;
                        sq.sq_x      <= LANE_X0;
                        sq.sq_y      <= LANE_Y;
                        sq.sq_colour <= colour_of(red_sh[0], yel_sh[0]);
                        sq.sq_go     <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (sq.sq_done) begin
                        if (slot == 4'd9) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            slot         <= slot_nxt;
                            sq.sq_x      <= sq.sq_x + PITCH;
                            sq.sq_colour <= colour_of(red_q[slot_nxt],
                                                      yellow_q[slot_nxt]);
                            sq.sq_go     <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Mid-frame requests: one tick may wait, anything more is lost.
            if (state != IDLE) begin
                if (tick) begin
                    if (pending)
                        overrun <= 1'b1;
                    else
                        pending <= 1'b1;
                end
                if (load)
                    overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_note_lane_sequencer.sv
// Directed bench for note_lane_sequencer with a simple drawer responder.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_note_lane_sequencer;
    logic       clk;
    logic       reset;
    logic       tick;
    logic       load;
    logic [9:0] red_seq_in;
    logic [9:0] yellow_seq_in;
    logic       busy;
    logic       frame_done;
    logic [1:0] lane_head;
    logic       overrun;

    note_lane_sequencer_if sq ();

    note_lane_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .load          (load),
        .red_seq_in    (red_seq_in),
        .yellow_seq_in (yellow_seq_in),
        .sq            (sq.master),
        .busy          (busy),
        .frame_done    (frame_done),
        .lane_head     (lane_head),
        .overrun       (overrun)
    );

    int total;
    int bad;

    logic [7:0] cap_x [0:31];
    logic [6:0] cap_y [0:31];
    logic [2:0] cap_c [0:31];
    int         cap_n;
    int         cap_fd;
    int         cap_ovr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Records every square issued over a window; answers each sq_go with
    // sq_done one cycle later (i.e. during WAIT).
    task automatic capture(input int cycles);
        logic go_prev;
        go_prev = 1'b0;
        cap_n   = 0;
        cap_fd  = 0;
        cap_ovr = 0;
        for (int i = 0; i < cycles; i++) begin
            if (sq.sq_go) begin
                if (cap_n < 32) begin
                    cap_x[cap_n] = sq.sq_x;
                    cap_y[cap_n] = sq.sq_y;
                    cap_c[cap_n] = sq.sq_colour;
                end
                cap_n++;
            end
            if (frame_done)
                cap_fd++;
            if (overrun)
                cap_ovr++;
            sq.sq_done = go_prev;
            go_prev    = sq.sq_go;
            @(negedge clk);
        end
        sq.sq_done = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (sq.sq_go !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl go=%b busy=%b fd=%b expected 0 0 0",
                     sq.sq_go, busy, frame_done);
        end
        total++;
        if (sq.sq_x !== 8'd0 || sq.sq_y !== 7'd0 || sq.sq_colour !== 3'd0) begin
            bad++;
            $display("FAIL reset_sq x=%0d y=%0d c=%b expected 0 0 000",
                     sq.sq_x, sq.sq_y, sq.sq_colour);
        end
        total++;
        if (lane_head !== 2'b00 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_misc head=%b ovr=%b expected 00 0",
                     lane_head, overrun);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_frame;
        logic [2:0] exp_c [0:9];
        exp_c = '{3'b000, 3'b100, 3'b000, 3'b100, 3'b000,
                  3'b100, 3'b000, 3'b100, 3'b100, 3'b000};
        red_seq_in    = 10'b0110101010;
        yellow_seq_in = 10'b0000000000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        capture(30);
        total++;
        if (cap_n !== 10 || cap_fd !== 1) begin
            bad++;
            $display("FAIL load_counts go=%0d fd=%0d expected 10 1",
                     cap_n, cap_fd);
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (cap_x[i] !== 8'(10 + 12 * i) || cap_y[i] !== 7'd56 ||
                cap_c[i] !== exp_c[i]) begin
                bad++;
                $display("FAIL load_slot%0d x=%0d y=%0d c=%b expected %0d 56 %b",
                         i, cap_x[i], cap_y[i], cap_c[i], 10 + 12 * i, exp_c[i]);
            end
        end
        total++;
        if (busy !== 1'b0 || cap_ovr !== 0) begin
            bad++;
            $display("FAIL load_end busy=%b ovr=%0d expected 0 0",
                     busy, cap_ovr);
        end
    endtask

    task automatic test_tick_shift;
        logic [2:0] exp_c [0:9];
        exp_c = '{3'b100, 3'b000, 3'b100, 3'b000, 3'b100,
                  3'b000, 3'b100, 3'b100, 3'b000, 3'b000};
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        capture(30);
        total++;
        if (lane_head !== 2'b00 || cap_n !== 10 || cap_fd !== 1) begin
            bad++;
            $display("FAIL tick_counts head=%b go=%0d fd=%0d expected 00 10 1",
                     lane_head, cap_n, cap_fd);
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (cap_c[i] !== exp_c[i]) begin
                bad++;
                $display("FAIL tick_slot%0d c=%b expected %b",
                         i, cap_c[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_load_tick_same;
        red_seq_in    = 10'b0000000001;
        yellow_seq_in = 10'b1000000010;
        load = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        load = 1'b0;
        tick = 1'b0;
        capture(30);
        total++;
        if (cap_ovr !== 0 || cap_n !== 10) begin
            bad++;
            $display("FAIL both_ovr ovr=%0d go=%0d expected 0 10",
                     cap_ovr, cap_n);
        end
        total++;
        if (cap_c[0] !== 3'b100 || cap_c[1] !== 3'b110 ||
            cap_c[9] !== 3'b110) begin
            bad++;
            $display("FAIL both_noshift c0=%b c1=%b c9=%b expected 100 110 110",
                     cap_c[0], cap_c[1], cap_c[9]);
        end
    endtask

    task automatic test_colour_priority;
        red_seq_in    = 10'b0000001000;
        yellow_seq_in = 10'b0000001000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        capture(30);
        total++;
        if (cap_c[3] !== 3'b100 || cap_c[2] !== 3'b000) begin
            bad++;
            $display("FAIL prio_both c3=%b c2=%b expected 100 000",
                     cap_c[3], cap_c[2]);
        end
        red_seq_in = 10'b0000000000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        capture(30);
        total++;
        if (cap_c[3] !== 3'b110 || cap_c[4] !== 3'b000) begin
            bad++;
            $display("FAIL prio_yellow c3=%b c4=%b expected 110 000",
                     cap_c[3], cap_c[4]);
        end
    endtask

    task automatic test_pending_overrun;
        red_seq_in    = 10'b1111111111;
        yellow_seq_in = 10'b0000000000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        total++;
        if (overrun !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL pend_first ovr=%b busy=%b expected 0 1",
                     overrun, busy);
        end
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL pend_second ovr=%b expected 1", overrun);
        end
        @(negedge clk);
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL pend_pulse ovr=%b expected 0", overrun);
        end
        red_seq_in    = 10'b0000000000;
        yellow_seq_in = 10'b1111111111;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL busy_load ovr=%b expected 1", overrun);
        end
        sq.sq_done = 1'b1;
        @(negedge clk);
        sq.sq_done = 1'b0;
        capture(60);
        total++;
        if (cap_n !== 19 || cap_fd !== 2 || cap_ovr !== 0) begin
            bad++;
            $display("FAIL pend_frames go=%0d fd=%0d ovr=%0d expected 19 2 0",
                     cap_n, cap_fd, cap_ovr);
        end
        total++;
        if (cap_c[0] !== 3'b100 || cap_x[0] !== 8'd22 ||
            cap_c[8] !== 3'b100 || cap_x[8] !== 8'd118) begin
            bad++;
            $display("FAIL pend_rest c0=%b x0=%0d c8=%b x8=%0d expected 100 22 100 118",
                     cap_c[0], cap_x[0], cap_c[8], cap_x[8]);
        end
        total++;
        if (cap_x[9] !== 8'd10 || cap_c[9] !== 3'b100 ||
            cap_x[18] !== 8'd118 || cap_c[18] !== 3'b000) begin
            bad++;
            $display("FAIL pend_redraw x9=%0d c9=%b x18=%0d c18=%b expected 10 100 118 000",
                     cap_x[9], cap_c[9], cap_x[18], cap_c[18]);
        end
        total++;
        if (lane_head !== 2'b01) begin
            bad++;
            $display("FAIL pend_head head=%b expected 01", lane_head);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic go_prev;
        logic found;
        go_prev = 1'b0;
        found   = 1'b0;
        red_seq_in    = 10'b0000011111;
        yellow_seq_in = 10'b0000000000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 40; i++) begin
            sq.sq_done = go_prev;
            go_prev    = sq.sq_go;
            if (sq.sq_go && sq.sq_x == 8'd58) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        sq.sq_done = 1'b0;
        total++;
        if (!found) begin
            bad++;
            $display("FAIL rst_slot4 not reached within 40 cycles");
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || sq.sq_x !== 8'd58) begin
            bad++;
            $display("FAIL rst_pre busy=%b x=%0d expected 1 58", busy, sq.sq_x);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (sq.sq_go !== 1'b0 || busy !== 1'b0 || sq.sq_x !== 8'd0) begin
            bad++;
            $display("FAIL rst_async go=%b busy=%b x=%0d expected 0 0 0",
                     sq.sq_go, busy, sq.sq_x);
        end
        @(negedge clk);
        reset = 1'b0;
        capture(30);
        total++;
        if (cap_n !== 0 || cap_fd !== 0) begin
            bad++;
            $display("FAIL rst_after go=%0d fd=%0d expected 0 0", cap_n, cap_fd);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b1;
        tick          = 1'b0;
        load          = 1'b0;
        red_seq_in    = '0;
        yellow_seq_in = '0;
        sq.sq_done    = 1'b0;
        test_reset();
        test_load_frame();
        test_tick_shift();
        test_load_tick_same();
        test_colour_priority();
        test_pending_overrun();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
